// File: rtl/reward_slot_scheduler.sv
// reward_slot_scheduler: owns the on-map reward table. Spawn requests are
// checked for duplicate coordinates and free space, then stored in the
// lowest free slot. Player pickups clear slots and pulse grant.
// Optional feature macro: REWARD_AGING_EN (slot lifetime countdown on tick_4hz).
module reward_slot_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int STAY_TICKS = 40,
    parameter int XW         = 5,
    parameter int YW         = 5,
    parameter int TW         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_4hz,
    input  logic          spawn_req,
    input  logic [TW-1:0] spawn_type,
    input  logic [XW-1:0] spawn_xpos,
    input  logic [YW-1:0] spawn_ypos,
    output logic          spawn_ack,
    output logic          spawn_rej,
    input  logic          player_vld,
    input  logic [XW-1:0] player_xpos,
    input  logic [YW-1:0] player_ypos,
    output logic          grant,
    output logic [TW-1:0] grant_type,
    output logic          expire,
    output logic [3:0]    occupancy,
    input  logic [2:0]    rd_idx,
    output logic          rd_vld,
    output logic [TW-1:0] rd_type,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP, DROP} state_t;

    state_t               state, state_next;
    logic [TW-1:0]        req_type;
    logic [XW-1:0]        req_x;
    logic [YW-1:0]        req_y;
    logic                 req_rej;

    logic [NUM_SLOTS-1:0] slot_vld, vld_next, free_oh, pick_oh;
    logic [TW-1:0]        slot_type [NUM_SLOTS];
    logic [XW-1:0]        slot_x    [NUM_SLOTS];
    logic [YW-1:0]        slot_y    [NUM_SLOTS];

    logic                 dup, full, write_en, pick_hit, expire_next;
    logic [TW-1:0]        pick_type;
    logic [3:0]           occ_next;

`ifdef REWARD_AGING_EN
    logic [7:0]           slot_life [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] age_out;
`endif

    // Table lookups on pre-edge state: dup/full for the latched request, lowest free slot, lowest pickup match
    always_comb begin
        dup       = 1'b0;
        full      = 1'b1;
        free_oh   = '0;
        pick_oh   = '0;
        pick_hit  = 1'b0;
        pick_type = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_vld[i] && slot_x[i] == req_x && slot_y[i] == req_y)
                dup = 1'b1;
            if (!slot_vld[i] && full) begin
                free_oh[i] = 1'b1;
                full       = 1'b0;
            end
            if (player_vld && slot_vld[i] && !pick_hit &&
                slot_x[i] == player_xpos && slot_y[i] == player_ypos) begin
                pick_oh[i] = 1'b1;
                pick_hit   = 1'b1;
                pick_type  = slot_type[i];
            end
        end
    end

    assign write_en = (state == CHECK) && !dup && !full;

`ifdef REWARD_AGING_EN
    // Slots whose life runs out on this tick; a same-edge pickup takes precedence
    always_comb begin
        age_out = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            age_out[i] = tick_4hz && slot_vld[i] && (slot_life[i] == 8'd1) && !pick_oh[i];
    end
    assign expire_next = |age_out;
`else
    logic unused_tick;
    assign unused_tick = tick_4hz;
    assign expire_next = 1'b0;
`endif

    // Next valid vector and its population count
    always_comb begin
        vld_next = slot_vld;
        occ_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pick_oh[i])
                vld_next[i] = 1'b0;
            else if (write_en && free_oh[i])
                vld_next[i] = 1'b1;
`ifdef REWARD_AGING_EN
            else if (age_out[i])
                vld_next[i] = 1'b0;
`endif
            if (vld_next[i])
                occ_next = occ_next + 4'd1;
        end
    end

    // Slot storage: valid bits, payload on write, life countdown when aging is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_type[i] <= '0;
                slot_x[i]    <= '0;
                slot_y[i]    <= '0;
`ifdef REWARD_AGING_EN
                slot_life[i] <= '0;
`endif
            end
        end else begin
            slot_vld <= vld_next;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (write_en && free_oh[i]) begin
                    slot_type[i] <= req_type;
                    slot_x[i]    <= req_x;
                    slot_y[i]    <= req_y;
`ifdef REWARD_AGING_EN
                    slot_life[i] <= 8'(STAY_TICKS);
                end else if (tick_4hz && slot_vld[i] && slot_life[i] != 8'd0) begin
                    slot_life[i] <= slot_life[i] - 8'd1;
`endif
                end
            end
        end
    end

    // Registered event pulses and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            grant_type <= '0;
            expire     <= 1'b0;
            occupancy  <= '0;
        end else begin
            grant      <= pick_hit && (pick_type != '0);
            grant_type <= pick_hit ? pick_type : '0;
            expire     <= expire_next;
            occupancy  <= occ_next;
        end
    end

    // Spawn FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Spawn FSM next-state: one response per request, then wait for the request to drop
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (spawn_req) state_next = CHECK;
            CHECK:   state_next = RESP;
            RESP:    state_next = DROP;
            DROP:    if (!spawn_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture on acceptance and reject flag from the CHECK cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_type <= '0;
            req_x    <= '0;
            req_y    <= '0;
            req_rej  <= 1'b0;
        end else begin
            if (state == IDLE && spawn_req) begin
                req_type <= spawn_type;
                req_x    <= spawn_xpos;
                req_y    <= spawn_ypos;
            end
            if (state == CHECK)
                req_rej <= dup | full;
        end
    end

    assign spawn_ack = (state == RESP);
    assign spawn_rej = (state == RESP) && req_rej;

    // Renderer view: invalid or out-of-range slots read as all zero
    always_comb begin
        rd_vld  = 1'b0;
        rd_type = '0;
        rd_x    = '0;
        rd_y    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_idx == 3'(i) && slot_vld[i]) begin
                rd_vld  = 1'b1;
                rd_type = slot_type[i];
                rd_x    = slot_x[i];
                rd_y    = slot_y[i];
            end
        end
    end

endmodule
